asi_rd_engine: RTL and testbench
================================

ASI_RD_ENGINE -- requirements
Module: asi_rd_engine

Interface
REQ-001 Parameter AXI_DW, default 128: data bus width in bits, power of two, 32 to 1024.
REQ-002 Parameter AXI_AW, default 40: address width in bits.
REQ-003 Parameter AXI_IW, default 8: ID width in bits.
REQ-004 Parameter AXI_LW, default 8: ARLEN width in bits.
REQ-005 Parameter SLV_OD, default 4: AR buffer depth, power of two.
REQ-006 Parameter SLV_RD, default 64: R buffer depth, power of two, at least SLV_WS+2.
REQ-007 Parameter SLV_WS, default 2: fixed user read latency in cycles, 0 to 8.
REQ-008 Port clk, in, 1: single clock for the AXI side and the user side.
REQ-009 Port rst_n, in, 1: reset, asynchronous, active-low.
REQ-010 Ports ARID/ARADDR/ARLEN/ARSIZE[3]/ARBURST[2]/ARVALID in, ARREADY out: AXI4 read address channel.
REQ-011 Ports RID/RDATA/RRESP[2]/RLAST/RVALID out, RREADY in: AXI4 read data channel.
REQ-012 Ports m_raddr[AW], m_re, m_rlast, m_rid[IW], m_rlen[LW], m_rsize[3], m_rburst[2] out: user beat request.
REQ-013 Ports m_rdata[DW], m_rvalid, m_rslverr in: user read return.
REQ-014 Port rgranted in, 1: arbiter grant. Port m_rbusy out, 1: equals m_re.
REQ-015 Port error_r4KB out, 1: one-cycle pulse on a 4KB violation.

Function
REQ-016 ARREADY SHALL equal not-full of the AR FIFO; an AR is pushed on ARVALID&ARREADY.
REQ-017 The FSM SHALL have states IDLE (reset state) and BURST; IDLE->BURST when the AR FIFO is non-empty (pop, latch fields, beat counter=0).
REQ-018 In BURST, m_re SHALL be 1 iff rgranted=1 and inflight+rff_count < SLV_RD, where inflight counts issued beats whose data has not yet returned.
REQ-019 On the issue of the last beat (counter==len), m_rlast=1; next state SHALL be BURST with the next AR popped in the same cycle if the FIFO is non-empty, else IDLE (no bubble between bursts).
REQ-020 m_raddr for beat 0 SHALL be ARADDR unmodified; FIXED: every beat = ARADDR; INCR: beat n = aligned(ARADDR)+n*2^size.
REQ-021 WRAP (see REQ-031): wrap span = (len+1)*2^size, lower = ARADDR rounded down to the span, address wraps to lower when it reaches lower+span.
REQ-022 For INCR, if a beat address would leave ARADDR's 4KB page, the address SHALL wrap within the page, error_r4KB SHALL pulse once per burst, and the remaining beats get SLVERR.
REQ-023 RRESP SHALL be 2'b10 when ARSIZE > log2(DW/8), when ARBURST==3, on a 4KB violation, or when m_rslverr=1 with that beat; otherwise 2'b00.
REQ-024 m_rvalid SHALL be required exactly SLV_WS cycles after m_re; RID, RLAST and the response flags SHALL be delayed SLV_WS stages and written with m_rdata into the R FIFO.
REQ-025 RVALID SHALL equal not-empty of the R FIFO; a pop on RVALID&RREADY; outputs held stable while RREADY=0.
REQ-026 The R FIFO SHALL never overflow; an m_rvalid pulse without a matching issue is ignored and does not change inflight.
REQ-027 Same-cycle m_re and m_rvalid SHALL leave inflight unchanged; len=0 bursts issue a single beat with m_rlast=1.

Reset
REQ-028 With rst_n=0: FSM=IDLE, FIFOs empty, inflight=0, m_re=0, m_rlast=0, RVALID=0, error_r4KB=0, ARREADY=1 after reset release.
REQ-029 Reset during a burst SHALL discard all queued ARs, in-flight beats and buffered data; no RVALID until new traffic arrives.
REQ-030 All other outputs SHALL be 0 in reset.

Configuration
REQ-031 Macro ASI_RD_WRAP_EN defined: WRAP bursts with len in {1,3,7,15} are supported as in REQ-021; other WRAP lens are answered SLVERR with INCR addressing.
REQ-032 Macro undefined: every WRAP burst is answered SLVERR on all beats and addressed as INCR.

Verification
REQ-033 INCR ARADDR=0x1004, len=3, size=4, DW=128 -> m_raddr 0x1004,0x1010,0x1020,0x1030; 4 R beats, RRESP=0, RLAST on the 4th.
REQ-034 WRAP (macro on) ARADDR=0x38, len=3, size=4 -> addresses 0x38,0x00,0x10,0x20; macro off -> RRESP=2'b10 on all 4 beats.
REQ-035 INCR ARADDR=0xFF0, len=1, size=4 -> error_r4KB pulses once; second beat address 0x000 and RRESP=2'b10.
REQ-036 SLV_RD=8, RREADY=0, 3 bursts len=7 -> m_re stops after 8 beats; no overflow; all 24 beats in order once RREADY=1.
REQ-037 Two back-to-back ARs with len=0, rgranted=1 -> m_re high in 2 consecutive cycles with m_rlast=1 on both; ARSIZE=5 on DW=128 -> RRESP=2'b10.
REQ-038 Assert rst_n=0 mid-burst with 3 beats buffered -> RVALID=0 next cycle; the next burst after reset completes normally.

Source files
------------

// File: rtl/asi_rd_engine.sv
// AXI4 read-slave engine.
// Buffers AXI read-address requests, expands each burst into one user beat request per cycle
// (FIXED / INCR / optional WRAP addressing with 4KB page protection), tracks the fixed-latency
// user return path and buffers returned data for the AXI R channel.
//
// Optional feature: define ASI_RD_WRAP_EN to support WRAP bursts with len 1/3/7/15.
// Without it every WRAP burst is addressed as INCR and answered SLVERR.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   AR* / ARREADY                   AXI4 read address channel
//   RID/RDATA/RRESP/RLAST/RVALID    AXI4 read data channel (RREADY in)
//   m_raddr..m_rburst, m_re         user beat request (m_rlast marks the last beat of a burst)
//   m_rdata, m_rvalid, m_rslverr    user read return, exactly SLV_WS cycles after m_re
//   rgranted                        arbiter grant; m_rbusy mirrors m_re
//   error_r4KB                      one-cycle pulse when an INCR burst leaves its 4KB page
module asi_rd_engine #(
  parameter int unsigned AXI_DW = 128,
  parameter int unsigned AXI_AW = 40,
  parameter int unsigned AXI_IW = 8,
  parameter int unsigned AXI_LW = 8,
  parameter int unsigned SLV_OD = 4,
  parameter int unsigned SLV_RD = 64,
  parameter int unsigned SLV_WS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AXI_IW-1:0] ARID,
  input  logic [AXI_AW-1:0] ARADDR,
  input  logic [AXI_LW-1:0] ARLEN,
  input  logic [2:0]        ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [AXI_IW-1:0] RID,
  output logic [AXI_DW-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [AXI_AW-1:0] m_raddr,
  output logic              m_re,
  output logic              m_rlast,
  output logic [AXI_IW-1:0] m_rid,
  output logic [AXI_LW-1:0] m_rlen,
  output logic [2:0]        m_rsize,
  output logic [1:0]        m_rburst,
  input  logic [AXI_DW-1:0] m_rdata,
  input  logic              m_rvalid,
  input  logic              m_rslverr,
  input  logic              rgranted,
  output logic              m_rbusy,
  output logic              error_r4KB
);

  localparam int unsigned SizeMax = $clog2(AXI_DW / 8);
  localparam int unsigned ArPw    = $clog2(SLV_OD);
  localparam int unsigned ArCw    = ArPw + 1;
  localparam int unsigned RPw     = $clog2(SLV_RD);
  localparam int unsigned RCw     = RPw + 1;
  localparam logic [RCw:0] RdLim  = (RCw + 1)'(SLV_RD);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [AXI_LW-1:0] len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_t;

  // ---------------------------------------------------------------- AR FIFO
  ar_t             ar_mem [SLV_OD];
  ar_t             ar_head;
  logic [ArPw-1:0] ar_wptr_q, ar_rptr_q;
  logic [ArCw-1:0] ar_count_q, ar_count_d;
  logic            ar_ready_q, ar_push, ar_pop, ar_nonempty;

  assign ARREADY     = ar_ready_q;
  assign ar_push     = ARVALID & ar_ready_q;
  assign ar_nonempty = (ar_count_q != '0);
  assign ar_head     = ar_mem[ar_rptr_q];
  assign ar_count_d  = ar_count_q + ArCw'(ar_push) - ArCw'(ar_pop);

  // ARREADY is registered so it stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_wptr_q  <= '0;
      ar_rptr_q  <= '0;
      ar_count_q <= '0;
      ar_ready_q <= 1'b0;
    end else begin
      if (ar_push) ar_wptr_q <= ar_wptr_q + 1'b1;
      if (ar_pop)  ar_rptr_q <= ar_rptr_q + 1'b1;
      ar_count_q <= ar_count_d;
      ar_ready_q <= (ar_count_d != ArCw'(SLV_OD));
    end
  end

  always_ff @(posedge clk) begin
    if (ar_push) ar_mem[ar_wptr_q] <= '{ARID, ARADDR, ARLEN, ARSIZE, ARBURST};
  end

  // Classify the head request at pop time.
  logic hd_wrap_ok, hd_err;
  always_comb begin
    hd_wrap_ok = 1'b0;
`ifdef ASI_RD_WRAP_EN
    hd_wrap_ok = (ar_head.burst == 2'b10) &&
                 ((ar_head.len == AXI_LW'(1)) || (ar_head.len == AXI_LW'(3)) ||
                  (ar_head.len == AXI_LW'(7)) || (ar_head.len == AXI_LW'(15)));
`endif
    hd_err = (ar_head.size > 3'(SizeMax)) || (ar_head.burst == 2'b11) ||
             ((ar_head.burst == 2'b10) && !hd_wrap_ok);
  end

  // ---------------------------------------------------------------- burst FSM
  state_e            state_q;
  logic [AXI_IW-1:0] id_q;
  logic [AXI_AW-1:0] addr_q;
  logic [AXI_LW-1:0] len_q, cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              fixed_q, wrap_q, err_q, r4k_q, err4k_q;

  logic [RCw-1:0]    inflight_q;
  logic [RCw-1:0]    rff_count_q;
  logic              space_ok, beat_last, issue_err;

  assign space_ok  = ({1'b0, inflight_q} + {1'b0, rff_count_q}) < RdLim;
  assign beat_last = (cnt_q == len_q);
  assign m_re      = (state_q == StBurst) && rgranted && space_ok;
  assign m_rlast   = m_re && beat_last;
  assign m_rbusy   = m_re;
  assign ar_pop    = ar_nonempty && ((state_q == StIdle) || m_rlast);
  assign issue_err = err_q | r4k_q;

  assign m_raddr    = addr_q;
  assign m_rid      = id_q;
  assign m_rlen     = len_q;
  assign m_rsize    = size_q;
  assign m_rburst   = burst_q;
  assign error_r4KB = err4k_q;

  // Next-beat address.
  logic [AXI_AW-1:0] step, incr_addr, wrap_mask, next_addr;
  logic              page_cross, cross_hit;
  always_comb begin
    step       = AXI_AW'(1) << size_q;
    incr_addr  = (addr_q & ~(step - AXI_AW'(1))) + step;
    // The wrap span is a power of two for supported lens, so the span minus one is a mask.
    wrap_mask  = ((AXI_AW'(len_q) + AXI_AW'(1)) << size_q) - AXI_AW'(1);
    page_cross = (incr_addr[AXI_AW-1:12] != addr_q[AXI_AW-1:12]);
    cross_hit  = !fixed_q && !wrap_q && page_cross;
    if (fixed_q) begin
      next_addr = addr_q;
    end else if (wrap_q) begin
      next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    end else if (page_cross) begin
      next_addr = {addr_q[AXI_AW-1:12], incr_addr[11:0]};
    end else begin
      next_addr = incr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      fixed_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      r4k_q   <= 1'b0;
      err4k_q <= 1'b0;
    end else begin
      err4k_q <= 1'b0;
      if ((state_q == StBurst) && m_re && !beat_last) begin
        cnt_q  <= cnt_q + 1'b1;
        addr_q <= next_addr;
        if (cross_hit) begin
          r4k_q <= 1'b1;
          if (!r4k_q) err4k_q <= 1'b1;
        end
      end
      // A pop on the last beat reloads directly so consecutive bursts have no bubble.
      if (ar_pop) begin
        state_q <= StBurst;
        id_q    <= ar_head.id;
        addr_q  <= ar_head.addr;
        len_q   <= ar_head.len;
        size_q  <= ar_head.size;
        burst_q <= ar_head.burst;
        cnt_q   <= '0;
        fixed_q <= (ar_head.burst == 2'b00);
        wrap_q  <= hd_wrap_ok;
        err_q   <= hd_err;
        r4k_q   <= 1'b0;
      end else if (m_rlast) begin
        state_q <= StIdle;
      end
    end
  end

  // ---------------------------------------------------------------- return pipeline
  logic              tail_valid, tail_last, tail_err;
  logic [AXI_IW-1:0] tail_id;

  if (SLV_WS == 0) begin : g_nodelay
    assign tail_valid = m_re;
    assign tail_id    = m_rid;
    assign tail_last  = m_rlast;
    assign tail_err   = issue_err;
  end else begin : g_delay
    logic [SLV_WS-1:0] pv_q, pl_q, pe_q;
    logic [AXI_IW-1:0] pid_q [SLV_WS];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv_q <= '0;
        pl_q <= '0;
        pe_q <= '0;
        for (int i = 0; i < SLV_WS; i++) pid_q[i] <= '0;
      end else begin
        pv_q[0]  <= m_re;
        pl_q[0]  <= m_rlast;
        pe_q[0]  <= issue_err;
        pid_q[0] <= m_rid;
        for (int i = 1; i < SLV_WS; i++) begin
          pv_q[i]  <= pv_q[i-1];
          pl_q[i]  <= pl_q[i-1];
          pe_q[i]  <= pe_q[i-1];
          pid_q[i] <= pid_q[i-1];
        end
      end
    end
    assign tail_valid = pv_q[SLV_WS-1];
    assign tail_id    = pid_q[SLV_WS-1];
    assign tail_last  = pl_q[SLV_WS-1];
    assign tail_err   = pe_q[SLV_WS-1];
  end

  // Return data without a matching issue slot is dropped.
  logic rff_push, rff_pop;
  assign rff_push = m_rvalid && tail_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      unique case ({m_re, rff_push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- R FIFO
  r_t             r_mem [SLV_RD];
  r_t             r_head;
  logic [RPw-1:0] r_wptr_q, r_rptr_q;

  assign RVALID  = (rff_count_q != '0);
  assign rff_pop = RVALID && RREADY;
  assign r_head  = r_mem[r_rptr_q];
  // Gate so stale storage never reaches the bus while empty.
  assign RID     = RVALID ? r_head.id   : '0;
  assign RDATA   = RVALID ? r_head.data : '0;
  assign RRESP   = RVALID ? r_head.resp : 2'b00;
  assign RLAST   = RVALID && r_head.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr_q    <= '0;
      r_rptr_q    <= '0;
      rff_count_q <= '0;
    end else begin
      if (rff_push) r_wptr_q <= r_wptr_q + 1'b1;
      if (rff_pop)  r_rptr_q <= r_rptr_q + 1'b1;
      rff_count_q <= rff_count_q + RCw'(rff_push) - RCw'(rff_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rff_push) begin
      r_mem[r_wptr_q] <= '{tail_id, m_rdata, (tail_err || m_rslverr) ? 2'b10 : 2'b00, tail_last};
    end
  end

endmodule

// File: tb/tb_asi_rd_engine.sv
module tb_asi_rd_engine;

  localparam int DW = 128;
  localparam int AW = 40;
  localparam int IW = 8;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [IW-1:0] ARID = '0;
  logic [AW-1:0] ARADDR = '0;
  logic [LW-1:0] ARLEN = '0;
  logic [2:0]    ARSIZE = '0;
  logic [1:0]    ARBURST = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST, RVALID;
  logic          RREADY = 1'b0;
  logic [AW-1:0] m_raddr;
  logic          m_re, m_rlast;
  logic [IW-1:0] m_rid;
  logic [LW-1:0] m_rlen;
  logic [2:0]    m_rsize;
  logic [1:0]    m_rburst;
  logic [DW-1:0] m_rdata = '0;
  logic          m_rvalid = 1'b0;
  logic          m_rslverr = 1'b0;
  logic          rgranted = 1'b0;
  logic          m_rbusy, error_r4KB;

  asi_rd_engine #(
    .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW),
    .SLV_OD(4), .SLV_RD(8), .SLV_WS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .m_raddr(m_raddr), .m_re(m_re), .m_rlast(m_rlast), .m_rid(m_rid), .m_rlen(m_rlen),
    .m_rsize(m_rsize), .m_rburst(m_rburst),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rslverr(m_rslverr),
    .rgranted(rgranted), .m_rbusy(m_rbusy), .error_r4KB(error_r4KB)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
    return {4{a[31:0] ^ 32'h5A5A_0000}};
  endfunction

  // User-side memory model: answers every request two cycles later.
  logic          re_d1 = 1'b0;
  logic [AW-1:0] addr_d1 = '0;
  always @(posedge clk) begin
    re_d1     <= m_re;
    addr_d1   <= m_raddr;
    m_rvalid  <= re_d1;
    m_rdata   <= fdata(addr_d1);
    m_rslverr <= re_d1 && (addr_d1 == 40'hBAD0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic [AW-1:0] iss_addr[$];
  logic          iss_last[$];
  int            iss_cyc[$];
  logic [IW-1:0] rb_id[$];
  logic [DW-1:0] rb_data[$];
  logic [1:0]    rb_resp[$];
  logic          rb_last[$];
  int            e4k_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_re) begin
        iss_addr.push_back(m_raddr);
        iss_last.push_back(m_rlast);
        iss_cyc.push_back(cyc);
      end
      if (RVALID && RREADY) begin
        rb_id.push_back(RID);
        rb_data.push_back(RDATA);
        rb_resp.push_back(RRESP);
        rb_last.push_back(RLAST);
      end
      if (error_r4KB) e4k_cnt = e4k_cnt + 1;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    iss_addr.delete(); iss_last.delete(); iss_cyc.delete();
    rb_id.delete(); rb_data.delete(); rb_resp.delete(); rb_last.delete();
    e4k_cnt = 0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    bit ok = 0;
    @(posedge clk); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ARREADY) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    chk("ar_accept", 128'(ok), 128'(1));
  endtask

  task automatic wait_beats(input int n, input int maxc);
    for (int k = 0; k < maxc; k++) begin
      if (rb_id.size() >= n) break;
      @(posedge clk);
    end
  endtask

  typedef struct {
    logic [IW-1:0]      id;
    logic [AW-1:0]      addr;
    logic [LW-1:0]      len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic [3:0][AW-1:0] ea;
    logic [3:0]         emask;
    int                 e4k;
  } vec_t;

  function automatic vec_t mkv(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                               input logic [LW-1:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [AW-1:0] a3, input logic [3:0] emask, input int e4k);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.emask = emask; v.e4k = e4k;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int nb;
    nb = int'(v.len) + 1;
    clear_mon();
    rgranted = 1'b1;
    RREADY   = 1'b1;
    send_ar(v.id, v.addr, v.len, v.size, v.burst);
    wait_beats(nb, 100);
    repeat (4) @(posedge clk);
    chk({tag, "_beats"}, 128'(rb_id.size()), 128'(nb));
    chk({tag, "_issues"}, 128'(iss_addr.size()), 128'(nb));
    for (int i = 0; i < nb && i < 4; i++) begin
      if (i < rb_id.size() && i < iss_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 128'(iss_addr[i]), 128'(v.ea[i]));
        chk($sformatf("%s_resp%0d", tag, i), 128'(rb_resp[i]), v.emask[i] ? 128'(2) : 128'(0));
        chk($sformatf("%s_last%0d", tag, i), 128'(rb_last[i]), 128'(i == nb - 1));
        chk($sformatf("%s_rid%0d", tag, i), 128'(rb_id[i]), 128'(v.id));
        chk($sformatf("%s_data%0d", tag, i), rb_data[i], fdata(v.ea[i]));
      end
    end
    chk({tag, "_e4k"}, 128'(e4k_cnt), 128'(v.e4k));
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mkv(8'h11, 40'h1004, 8'd3, 3'd4, 2'b01,
                  40'h1004, 40'h1010, 40'h1020, 40'h1030, 4'b0000, 0);
`ifdef ASI_RD_WRAP_EN
    vecs[1] = mkv(8'h12, 40'h0038, 8'd3, 3'd4, 2'b10,
                  40'h0038, 40'h0000, 40'h0010, 40'h0020, 4'b0000, 0);
    vecs[8] = mkv(8'h19, 40'h0014, 8'd1, 3'd2, 2'b10,
                  40'h0014, 40'h0010, 40'h0, 40'h0, 4'b0000, 0);
`else
    vecs[1] = mkv(8'h12, 40'h0038, 8'd3, 3'd4, 2'b10,
                  40'h0038, 40'h0040, 40'h0050, 40'h0060, 4'b1111, 0);
    vecs[8] = mkv(8'h19, 40'h0014, 8'd1, 3'd2, 2'b10,
                  40'h0014, 40'h0018, 40'h0, 40'h0, 4'b0011, 0);
`endif
    vecs[2] = mkv(8'h13, 40'h0FF0, 8'd1, 3'd4, 2'b01,
                  40'h0FF0, 40'h0000, 40'h0, 40'h0, 4'b0010, 1);
    vecs[3] = mkv(8'h14, 40'h0200, 8'd2, 3'd2, 2'b00,
                  40'h0200, 40'h0200, 40'h0200, 40'h0, 4'b0000, 0);
    vecs[4] = mkv(8'h15, 40'h0100, 8'd0, 3'd5, 2'b01,
                  40'h0100, 40'h0, 40'h0, 40'h0, 4'b0001, 0);
    vecs[5] = mkv(8'h16, 40'h0300, 8'd1, 3'd2, 2'b11,
                  40'h0300, 40'h0304, 40'h0, 40'h0, 4'b0011, 0);
    vecs[6] = mkv(8'h17, 40'hBAC8, 8'd3, 3'd3, 2'b01,
                  40'hBAC8, 40'hBAD0, 40'hBAD8, 40'hBAE0, 4'b0010, 0);
    vecs[7] = mkv(8'h18, 40'h0040, 8'd2, 3'd2, 2'b10,
                  40'h0040, 40'h0044, 40'h0048, 40'h0, 4'b0111, 0);

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 128'(ARREADY), 128'(0));
    chk("rst_rvalid", 128'(RVALID), 128'(0));
    chk("rst_m_re", 128'(m_re), 128'(0));
    chk("rst_m_rlast", 128'(m_rlast), 128'(0));
    chk("rst_err4k", 128'(error_r4KB), 128'(0));
    chk("rst_m_raddr", 128'(m_raddr), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_arready", 128'(ARREADY), 128'(1));

    // Single-burst table
    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // R buffer back-pressure: 3 x 8 beats into an 8-entry buffer
    begin
      logic [AW-1:0] base[3];
      base[0] = 40'h2000; base[1] = 40'h3000; base[2] = 40'h4000;
      clear_mon();
      RREADY = 1'b0;
      rgranted = 1'b1;
      for (int b = 0; b < 3; b++) send_ar(8'h31 + 8'(b), base[b], 8'd7, 3'd4, 2'b01);
      repeat (40) @(posedge clk);
      #1;
      chk("stall_issues", 128'(iss_addr.size()), 128'(8));
      chk("stall_rvalid", 128'(RVALID), 128'(1));
      RREADY = 1'b1;
      wait_beats(24, 300);
      repeat (4) @(posedge clk);
      chk("stall_beats", 128'(rb_id.size()), 128'(24));
      chk("stall_total_issues", 128'(iss_addr.size()), 128'(24));
      for (int k = 0; k < 24 && k < rb_id.size(); k++) begin
        logic [AW-1:0] ea;
        ea = base[k / 8] + AW'((k % 8) * 16);
        chk($sformatf("stall_data%0d", k), rb_data[k], fdata(ea));
        chk($sformatf("stall_last%0d", k), 128'(rb_last[k]), 128'((k % 8) == 7));
        chk($sformatf("stall_rid%0d", k), 128'(rb_id[k]), 128'(8'h31 + 8'(k / 8)));
      end
    end

    // Back-to-back single-beat bursts, no bubble
    clear_mon();
    rgranted = 1'b0;
    RREADY = 1'b1;
    send_ar(8'h41, 40'h0500, 8'd0, 3'd4, 2'b01);
    send_ar(8'h42, 40'h0600, 8'd0, 3'd5, 2'b01);
    repeat (2) @(posedge clk);
    #1 rgranted = 1'b1;
    repeat (20) @(posedge clk);
    chk("b2b_issues", 128'(iss_addr.size()), 128'(2));
    chk("b2b_beats", 128'(rb_id.size()), 128'(2));
    if (iss_addr.size() == 2) begin
      chk("b2b_consecutive", 128'(iss_cyc[1] - iss_cyc[0]), 128'(1));
      chk("b2b_last0", 128'(iss_last[0]), 128'(1));
      chk("b2b_last1", 128'(iss_last[1]), 128'(1));
    end
    if (rb_id.size() == 2) begin
      chk("b2b_resp0", 128'(rb_resp[0]), 128'(0));
      chk("b2b_resp1", 128'(rb_resp[1]), 128'(2));
    end

    // Reset in the middle of a burst with data buffered
    clear_mon();
    RREADY = 1'b0;
    rgranted = 1'b1;
    send_ar(8'h51, 40'h7000, 8'd7, 3'd4, 2'b01);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (iss_addr.size() >= 5) break;
    end
    chk("mid_rvalid", 128'(RVALID), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 128'(RVALID), 128'(0));
    chk("mid_rst_m_re", 128'(m_re), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    RREADY = 1'b1;
    repeat (10) @(posedge clk);
    chk("post_mid_beats", 128'(rb_id.size()), 128'(0));
    chk("post_mid_issues", 128'(iss_addr.size()), 128'(0));
    run_vec(vecs[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
